// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and D-cache.
// One line transaction at a time; alternating priority on conflict.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;  // 0 = I-cache, 1 = D-cache
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic req_i, req_d, grant_i, grant_d;

  assign req_i = icache_pmem_read;
  assign req_d = dcache_pmem_read | dcache_pmem_write;
  // On conflict the side that was not served last wins.
  assign grant_d = req_d & (~req_i | ~last_grant_q);
  assign grant_i = req_i & ~grant_d;

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    read_d           = read_q;
    write_d          = write_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d      = StServeI;
          last_grant_d = 1'b0;
          read_d       = 1'b1;
          write_d      = 1'b0;
          addr_d       = icache_pmem_address;
        end else if (grant_d) begin
          state_d      = StServeD;
          last_grant_d = 1'b1;
          read_d       = ~dcache_pmem_write;
          write_d      = dcache_pmem_write;
          addr_d       = dcache_pmem_address;
          wdata_d      = dcache_pmem_wdata;
        end
      end
      StServeI: begin
        if (pmem_resp) begin
          icache_pmem_resp = 1'b1;
          state_d          = StIdle;
          read_d           = 1'b0;
          write_d          = 1'b0;
        end
      end
      StServeD: begin
        if (pmem_resp) begin
          dcache_pmem_resp = 1'b1;
          state_d          = StIdle;
          read_d           = 1'b0;
          write_d          = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign pmem_read         = read_q;
  assign pmem_write        = write_q;
  assign pmem_address      = addr_q;
  assign pmem_wdata        = wdata_q;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus random traffic, all checked against a
// transaction-level model (pending transaction + last winner).
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic [127:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk                 (clk),
    .reset               (reset),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  // Transaction-level model: at most one pending memory transaction.
  bit           m_busy;
  bit           m_owner_d;   // owner of the pending transaction
  bit           m_last_d;    // last winner was the D-cache
  bit           m_is_write;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  bit           exp_iresp, exp_dresp;

  localparam logic [127:0] Pattern = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy     = 0;
    m_owner_d  = 0;
    m_last_d   = 0;
    m_is_write = 0;
    m_addr     = '0;
    m_wdata    = '0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    bit want_i, want_d, win_d;
    #1;
    exp_iresp = m_busy && !m_owner_d && pmem_resp && !reset;
    exp_dresp = m_busy &&  m_owner_d && pmem_resp && !reset;
    chk("pmem_read",   pmem_read,   m_busy && !m_is_write);
    chk("pmem_write",  pmem_write,  m_busy &&  m_is_write);
    chk("pmem_addr",   pmem_address, m_addr);
    chk("pmem_wdata",  pmem_wdata,  m_wdata);
    chk("icache_resp", icache_pmem_resp, exp_iresp);
    chk("dcache_resp", dcache_pmem_resp, exp_dresp);
    chk("i_rdata",     icache_pmem_rdata, pmem_rdata);
    chk("d_rdata",     dcache_pmem_rdata, pmem_rdata);
    @(posedge clk);
    if (!reset) begin
      if (m_busy) begin
        if (pmem_resp) m_busy = 0;
      end else begin
        want_i = icache_pmem_read;
        want_d = dcache_pmem_read || dcache_pmem_write;
        if (want_i || want_d) begin
          if (want_i && want_d) win_d = !m_last_d;
          else                  win_d = want_d;
          m_busy    = 1;
          m_owner_d = win_d;
          m_last_d  = win_d;
          if (win_d) begin
            m_is_write = dcache_pmem_write;
            m_addr     = dcache_pmem_address;
            m_wdata    = dcache_pmem_wdata;
          end else begin
            m_is_write = 0;
            m_addr     = icache_pmem_address;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    pmem_resp = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic respond();
    pmem_resp = 1;
    step();
    pmem_resp = 0;
  endtask

  initial begin
    logic [15:0] ia, da;
    reset = 1;
    icache_pmem_read = 0; icache_pmem_address = '0;
    dcache_pmem_read = 0; dcache_pmem_write = 0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    model_reset();
    @(negedge clk);
    phase = "reset";
    step();
    reset = 0;
    step();

    // 1: lone I read, response five cycles after the grant
    phase = "t1";
    icache_pmem_read = 1; icache_pmem_address = 16'h1230;
    step();
    chk("t1_read_cycle1", pmem_read, 1'b1);
    chk("t1_addr", pmem_address, 16'h1230);
    wait_cycles(4);
    respond();
    chk("t1_iresp_seen", exp_iresp, 1'b1);
    icache_pmem_read = 0;
    step();
    chk("t1_read_cleared", pmem_read, 1'b0);

    // 2: simultaneous requests after reset; D must win first
    phase = "t2";
    icache_pmem_read = 1; icache_pmem_address = 16'h1000;
    dcache_pmem_read = 1; dcache_pmem_address = 16'h2000;
    step();
    chk("t2_d_first", pmem_address, 16'h2000);
    wait_cycles(2);
    respond();
    dcache_pmem_read = 0;
    step();                           // mandatory idle cycle
    chk("t2_i_second", pmem_address, 16'h1000);
    chk("t2_i_read", pmem_read, 1'b1);
    wait_cycles(1);
    respond();
    icache_pmem_read = 0;
    step();

    // 3: continuous requests alternate D, I, D, I
    phase = "t3";
    icache_pmem_read = 1; dcache_pmem_read = 1;
    for (int k = 0; k < 4; k++) begin
      icache_pmem_address = 16'h3000 + 16'(k);
      dcache_pmem_address = 16'h5000 + 16'(k);
      step();
      chk("t3_alternate", pmem_address, (k % 2 == 0) ? 16'h5000 + 16'(k) : 16'h3000 + 16'(k));
      wait_cycles(1);
      respond();
    end
    icache_pmem_read = 0; dcache_pmem_read = 0;
    step();

    // 4: D writeback with inputs disturbed while being served
    phase = "t4";
    dcache_pmem_write = 1; dcache_pmem_address = 16'h4440; dcache_pmem_wdata = Pattern;
    step();
    dcache_pmem_write = 0; dcache_pmem_read = 1;
    dcache_pmem_address = 16'h9999; dcache_pmem_wdata = ~Pattern;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_write", pmem_write, 1'b1);
      chk("t4_noread", pmem_read, 1'b0);
      chk("t4_addr", pmem_address, 16'h4440);
      chk("t4_wdata", pmem_wdata, Pattern);
    end
    dcache_pmem_write = 1; dcache_pmem_read = 0;
    respond();
    dcache_pmem_write = 0;
    step();

    // 5: read+write together means write; stray resp in idle goes nowhere
    phase = "t5";
    dcache_pmem_read = 1; dcache_pmem_write = 1; dcache_pmem_address = 16'h0770;
    step();
    chk("t5_write", pmem_write, 1'b1);
    chk("t5_noread", pmem_read, 1'b0);
    respond();
    dcache_pmem_read = 0; dcache_pmem_write = 0;
    pmem_resp = 1;
    step();
    chk("t5_spur_i", exp_iresp, 1'b0);
    pmem_resp = 0;
    step();

    // 6: reset in the middle of a D transaction
    phase = "t6";
    dcache_pmem_read = 1; dcache_pmem_address = 16'h6660;
    step();
    wait_cycles(1);
    reset = 1;
    model_reset();
    pmem_resp = 1;
    #1;
    chk("t6_async_read", pmem_read, 1'b0);
    chk("t6_async_addr", pmem_address, 16'h0000);
    chk("t6_no_dresp", dcache_pmem_resp, 1'b0);
    step();
    pmem_resp = 0;
    dcache_pmem_read = 0;
    reset = 0;
    step();
    chk("t6_idle", pmem_read, 1'b0);
    icache_pmem_read = 1; icache_pmem_address = 16'h0110;
    dcache_pmem_read = 1; dcache_pmem_address = 16'h0220;
    step();
    chk("t6_d_first_again", pmem_address, 16'h0220);
    respond();
    icache_pmem_read = 0; dcache_pmem_read = 0;
    step();

    // Random traffic: caches hold requests until their resp, memory responds at random.
    phase = "rand";
    for (int n = 0; n < 400; n++) begin
      if (!icache_pmem_read && $urandom_range(0, 2) == 0) begin
        icache_pmem_read    = 1;
        icache_pmem_address = 16'($urandom);
      end
      if (!dcache_pmem_read && !dcache_pmem_write && $urandom_range(0, 2) == 0) begin
        ia = 16'($urandom_range(1, 3));
        dcache_pmem_read    = ia[0];
        dcache_pmem_write   = ia[1];
        da                  = 16'($urandom);
        dcache_pmem_address = da;
        dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      pmem_resp  = ($urandom_range(0, 2) == 0);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (exp_iresp) icache_pmem_read = 0;
      if (exp_dresp) begin
        dcache_pmem_read  = 0;
        dcache_pmem_write = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
